// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Holds the FSM state encoding, the pattern length mask and the counter ceiling.
package seqdet_pkg;

    localparam int MAX_LEN_LIMIT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        MATCH = 2'd2
    } state_t;

    // Low 'len' bits set; callers truncate to their own pattern width.
    function automatic logic [MAX_LEN_LIMIT-1:0] len_mask(input logic [31:0] len);
        if (len >= 32'd32) begin
            return '1;
        end
        return (32'd1 << len) - 32'd1;
    endfunction

    // All-ones value of a counter that is 'width' bits wide.
    function automatic logic [31:0] cnt_max(input int width);
        if (width >= 32) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter with synchronous clear, used to count pattern matches.
// Clear wins over increment; the count sticks at its all-ones value.
module seqdet_sat_counter
    import seqdet_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prog_seq_detector_moore.sv
// Moore serial pattern detector with a runtime-programmable pattern, length and
// overlap mode; reports a one-cycle match flag and a saturating match count.
module prog_seq_detector_moore
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din_valid,
    input  logic               din,
    output logic               dout,
    output logic [CNT_W-1:0]   match_count,
    output logic               active
);

    state_t             state;
    state_t             state_d;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;

    // The oldest history bit is shifted out before it is ever compared, so
    // only MAX_LEN-1 bits need storing; the compare sees them plus din.
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-2:0] hist_d;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_inc;
    logic               hit;
    logic               cfg_ok;
    logic               cnt_clear;
    logic               cnt_inc;

    assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pattern <= '0;
            len     <= '0;
            overlap <= 1'b0;
            hist    <= '0;
            fill    <= '0;
        end else begin
            state <= state_d;
            hist  <= hist_d;
            fill  <= fill_d;
            if (cfg_load) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
            end
        end
    end

    always_comb begin
        hist_shift = {hist, din};
        fill_inc   = (fill == len) ? len : fill + LEN_W'(1);
        mask       = MAX_LEN'(len_mask(32'(len)));
        // fill guards against matching on the zeroed history after a clear
        hit        = (fill_inc == len) && (((hist_shift ^ pattern) & mask) == '0);

        state_d   = state;
        hist_d    = hist;
        fill_d    = fill;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;

        if (cfg_load) begin
            state_d   = cfg_ok ? HUNT : IDLE;
            hist_d    = '0;
            fill_d    = '0;
            cnt_clear = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_d = IDLE;
                end
                HUNT, MATCH: begin
                    if (din_valid) begin
                        hist_d = hist_shift[MAX_LEN-2:0];
                        fill_d = fill_inc;
                        if (hit) begin
                            state_d = MATCH;
                            cnt_inc = 1'b1;
                            if (!overlap) begin
                                fill_d = '0;
                            end
                        end else begin
                            state_d = HUNT;
                        end
                    end else begin
                        state_d = HUNT;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign dout   = (state == MATCH);
    assign active = (state != IDLE);

    seqdet_sat_counter #(
        .CNT_W(CNT_W)
    ) u_match_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .count  (match_count)
    );

endmodule

// File: tb/tb_prog_seq_detector_moore.sv
// Bench for prog_seq_detector_moore: vector table, reset corner cases and a
// randomized run against a queue-based model (8-bit and 2-bit counter instances).
module tb_prog_seq_detector_moore;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               din_valid;
    logic               din;
    logic               dout;
    logic               dout_s;
    logic               active;
    logic               active_s;
    logic [7:0]         match_count;
    logic [1:0]         match_count_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prog_seq_detector_moore #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
        .dout(dout), .match_count(match_count), .active(active)
    );

    prog_seq_detector_moore #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
        .dout(dout_s), .match_count(match_count_s), .active(active_s)
    );

    // Reference model: the valid bits seen since the last clear, oldest first.
    bit         m_hist[$];
    bit [7:0]   m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_active;
    bit         m_dout;
    int         m_count;

    function automatic int sat(input int c, input int maxv);
        return (c > maxv) ? maxv : c;
    endfunction

    function automatic void model_reset();
        m_hist.delete();
        m_pat    = '0;
        m_len    = 0;
        m_ovl    = 1'b0;
        m_active = 1'b0;
        m_dout   = 1'b0;
        m_count  = 0;
    endfunction

    function automatic bit tail_matches();
        if (m_hist.size() != m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (m_hist[i] != m_pat[m_len-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_step();
        if (cfg_load) begin
            m_pat    = cfg_pattern;
            m_len    = int'(cfg_len);
            m_ovl    = cfg_overlap;
            m_active = (m_len >= 1) && (m_len <= MAX_LEN);
            m_hist.delete();
            m_count  = 0;
            m_dout   = 1'b0;
        end else if (m_active && din_valid) begin
            m_hist.push_back(din);
            if (m_hist.size() > m_len) void'(m_hist.pop_front());
            m_dout = tail_matches();
            if (m_dout) begin
                m_count++;
                if (!m_ovl) m_hist.delete();
            end
        end else begin
            m_dout = 1'b0;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_dout"},    int'(dout),          int'(m_dout));
        check({tag, "_active"},  int'(active),        int'(m_active));
        check({tag, "_count"},   int'(match_count),   sat(m_count, 255));
        check({tag, "_dout_s"},  int'(dout_s),        int'(m_dout));
        check({tag, "_count_s"}, int'(match_count_s), sat(m_count, 3));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit ld, input bit [7:0] pat, input bit [3:0] len,
                         input bit ovl, input bit vld, input bit d);
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        din_valid   = vld;
        din         = d;
    endtask

    typedef struct {
        bit       load;
        bit [7:0] pat;
        bit [3:0] len;
        bit       ovl;
        bit       vld;
        bit       d;
        bit       e_dout;
        int       e_cnt;
        bit       e_act;
    } vec_t;

    vec_t vecs[$];

    // Loads always present a valid '1' bit too, which must be dropped.
    function automatic void ld(input bit [7:0] pat, input bit [3:0] len, input bit ovl, input bit e_act);
        vec_t v;
        v = '{load: 1'b1, pat: pat, len: len, ovl: ovl, vld: 1'b1, d: 1'b1,
              e_dout: 1'b0, e_cnt: 0, e_act: e_act};
        vecs.push_back(v);
    endfunction

    function automatic void bt(input bit vld, input bit d, input bit e_dout, input int e_cnt, input bit e_act);
        vec_t v;
        v = '{load: 1'b0, pat: 8'hA5, len: 4'd3, ovl: 1'b0, vld: vld, d: d,
              e_dout: e_dout, e_cnt: e_cnt, e_act: e_act};
        vecs.push_back(v);
    endfunction

    initial begin
        // Overlapping 1101 on 1,0,1,1,0,1,1,0,1
        ld(8'b1101, 4'd4, 1'b1, 1'b1);
        bt(1,1,0,0,1); bt(1,0,0,0,1); bt(1,1,0,0,1); bt(1,1,0,0,1); bt(1,0,0,0,1);
        bt(1,1,1,1,1); bt(1,1,0,1,1); bt(1,0,0,1,1); bt(1,1,1,2,1);
        // Same stream, non-overlapping
        ld(8'b1101, 4'd4, 1'b0, 1'b1);
        bt(1,1,0,0,1); bt(1,0,0,0,1); bt(1,1,0,0,1); bt(1,1,0,0,1); bt(1,0,0,0,1);
        bt(1,1,1,1,1); bt(1,1,0,1,1); bt(1,0,0,1,1); bt(1,1,0,1,1);
        // Single-bit pattern, back-to-back matches, 2-bit counter saturates
        ld(8'b1, 4'd1, 1'b1, 1'b1);
        bt(1,1,1,1,1); bt(1,1,1,2,1); bt(1,1,1,3,1); bt(1,1,1,4,1); bt(1,1,1,5,1);
        bt(0,1,0,5,1);
        // 1101 with valid gaps
        ld(8'b1101, 4'd4, 1'b1, 1'b1);
        bt(1,1,0,0,1); bt(0,0,0,0,1); bt(1,1,0,0,1); bt(0,1,0,0,1); bt(0,0,0,0,1);
        bt(1,0,0,0,1); bt(1,1,1,1,1); bt(0,0,0,1,1); bt(0,1,0,1,1);
        // Invalid lengths disable detection
        ld(8'b1101, 4'd0, 1'b1, 1'b0);
        bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,1,0,0,0);
        ld(8'b1101, 4'd9, 1'b1, 1'b0);
        bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,1,0,0,0);
        // Valid reload, overlapping "11"
        ld(8'b11, 4'd2, 1'b1, 1'b1);
        bt(1,1,0,0,1); bt(1,1,1,1,1); bt(1,1,1,2,1); bt(0,1,0,2,1);

        reset_n = 1'b0;
        drive(0, 8'h00, 4'd0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout",   int'(dout),        0);
        check("rst_active", int'(active),      0);
        check("rst_count",  int'(match_count), 0);
        #2 reset_n = 1'b1;

        // IDLE ignores data until a config is loaded
        drive(0, 8'h00, 4'd0, 0, 1, 1);
        repeat (3) tick();
        check_model("idle");
        check("idle_active", int'(active), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].load, vecs[i].pat, vecs[i].len, vecs[i].ovl, vecs[i].vld, vecs[i].d);
            tick();
            check($sformatf("vec%0d_dout", i),    int'(dout),          int'(vecs[i].e_dout));
            check($sformatf("vec%0d_active", i),  int'(active),        int'(vecs[i].e_act));
            check($sformatf("vec%0d_count", i),   int'(match_count),   vecs[i].e_cnt);
            check($sformatf("vec%0d_count_s", i), int'(match_count_s), sat(vecs[i].e_cnt, 3));
        end

        // Async reset while the match flag is high
        drive(1, 8'b1101, 4'd4, 1, 0, 0); tick();
        drive(0, 8'h00, 4'd0, 0, 1, 1); tick(); tick();
        din = 1'b0; tick();
        din = 1'b1; tick();
        check("pre_rst_dout", int'(dout), 1);
        check("pre_rst_count", int'(match_count), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_dout",   int'(dout),        0);
        check("async_rst_active", int'(active),      0);
        check("async_rst_count",  int'(match_count), 0);
        model_reset();
        #2 reset_n = 1'b1;

        // Async reset mid-pattern after 1,1,0: trailing 1 must not match
        drive(1, 8'b1101, 4'd4, 1, 0, 0); tick();
        drive(0, 8'h00, 4'd0, 0, 1, 1); tick(); tick();
        din = 1'b0; tick();
        check("mid_active", int'(active), 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_active", int'(active), 0);
        check("mid_rst_dout",   int'(dout),   0);
        model_reset();
        #2 reset_n = 1'b1;
        drive(1, 8'b1101, 4'd4, 1, 0, 0); tick();
        check_model("reload");
        drive(0, 8'h00, 4'd0, 0, 1, 1); tick();
        check("trail_dout",  int'(dout),        0);
        check("trail_count", int'(match_count), 0);
        drive(0, 8'h00, 4'd0, 0, 0, 0); tick();
        check("trail_dout2", int'(dout), 0);

        // Randomized run against the model; config fields churn while ignored
        for (int i = 0; i < 1500; i++) begin
            cfg_load    = (i == 0) || ($urandom_range(0, 49) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = ($urandom_range(0, 15) > 12) ? 4'($urandom_range(0, 9))
                                                      : 4'($urandom_range(1, 4));
            cfg_overlap = 1'($urandom_range(0, 1));
            din_valid   = ($urandom_range(0, 3) != 0);
            din         = 1'($urandom_range(0, 1));
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_seq_detector_moore.md
Name: prog_seq_detector_moore

Overview:
Parametrised Moore-style serial pattern detector, successor to the fixed 1101 detector. The pattern (up to MAX_LEN bits) and its length are runtime-programmable. Overlapping or non-overlapping detection is selectable. A valid-qualified bit stream is monitored, a registered one-cycle match flag is produced, and a saturating match counter is kept for status readout.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
CNT_W, 8, width of the saturating match counter
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
cfg_load  input  1  single-cycle strobe; latch cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is first received, bit [0] last
cfg_len  input  LEN_W  pattern length; 0 or >MAX_LEN disables detection
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after a match
din_valid  input  1  din is sampled only when high
din  input  1  serial data bit
dout  output  1  Moore match flag, registered
match_count  output  CNT_W  number of matches since reset/cfg_load, saturating
active  output  1  1 when a valid config is loaded (state != IDLE)

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, dout=0, match_count=0, active=0.
  - Shadow pattern=0, length=0, overlap=0.
  - History register and fill counter = 0.
- FSM states:
  - IDLE: no valid config.
  - HUNT: collecting bits.
  - MATCH: pattern just completed.
- Outputs from state only:
  - dout=1 iff state==MATCH.
  - active=1 iff state!=IDLE.
- cfg_load=1 (has priority over din_valid in the same cycle; that din bit is dropped):
  - Latch the config.
  - Clear history, fill and match_count.
  - Next state = HUNT if 1<=cfg_len<=MAX_LEN, else IDLE.
- IDLE: ignores din; stays until a valid cfg_load.
- HUNT/MATCH with din_valid=1:
  - hist <= {hist[MAX_LEN-2:0], din}.
  - fill <= min(fill+1, len).
- Match condition, evaluated on the post-shift values:
  - new fill == len, and
  - new hist[len-1:0] == pattern[len-1:0].
  - Comparison is masked to len bits.
- On a match:
  - Next state = MATCH.
  - match_count increments, saturating at 2^CNT_W-1.
  - If overlap=0, fill <= 0; the history contents are don't-care once fill is 0.
- On no match with din_valid=1: next state = HUNT.
- din_valid=0:
  - hist and fill hold.
  - MATCH -> HUNT, so dout is one cycle wide.
  - HUNT holds.
- Latency: dout rises in the cycle immediately after the clock edge that samples the final pattern bit.
- Back-to-back matches (e.g. pattern "1", len 1, or "11" with overlap):
  - MATCH -> MATCH.
  - dout stays high across consecutive valid cycles, one count per match.
- First match requires len valid bits since reset/cfg_load; the fill counter prevents false matches on zero-filled history.
- Config inputs are ignored except when cfg_load=1.
- Asserting reset_n=0 mid-stream aborts immediately; there is no pending output after release.

Decomposition:
- Shared package seqdet_pkg:
  - State typedef (IDLE, HUNT, MATCH).
  - Function len_mask(len) returning a MAX_LEN-bit mask.
  - Constant for the saturating counter max.
- One natural sub-module: seqdet_sat_counter (CNT_W, clear, inc, saturate).
- Shift/compare/FSM remain in the top module.

Test Plan:
- Reset, then cfg_load pattern=4'b1101, len=4, overlap=1; stream 1,0,1,1,0,1,1,0,1 (valid every cycle) -> dout pulses after bit 6 and after bit 9; match_count=2.
- Same stream, overlap=0 -> single dout pulse after bit 6; match_count=1.
- pattern=1, len=1, overlap=1; stream 1,1,1 -> dout high for 3 consecutive cycles; match_count=3. Repeat with CNT_W=2 and 5 ones -> match_count saturates at 3.
- pattern 1101 with din_valid gaps (1,gap,1,gap,gap,0,1) -> exactly one match; dout=0 during gap cycles except the single MATCH cycle.
- cfg_len=0 and cfg_len=MAX_LEN+1 -> active=0; dout never asserts on any stream. Then a valid cfg_load -> active=1 the next cycle and match_count=0.
- Drive reset_n=0 asynchronously mid-pattern (after 1,1,0) -> dout=0, match_count=0 and active=0 immediately. After release and reload, the trailing bit 1 alone produces no match.
